// File: rtl/mult_div_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer handshake and HI/LO result bus.
interface mult_div_sequencer_if #(
    parameter int DATA_BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BUS_WIDTH = 6
);
    logic                           i_flush;
    logic                           i_start;
    logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct;
    logic [DATA_BUS_WIDTH-1:0]      i_rs;
    logic [DATA_BUS_WIDTH-1:0]      i_rt;
    logic [DATA_BUS_WIDTH-1:0]      o_hi;
    logic [DATA_BUS_WIDTH-1:0]      o_lo;
    logic                           o_busy;
    logic                           o_stall;
    logic                           o_done;
    logic                           o_div_by_zero;

    // EX stage side: issues requests, observes HI/LO and status
    modport master (
        output i_flush, i_start, i_funct, i_rs, i_rt,
        input  o_hi, o_lo, o_busy, o_stall, o_done, o_div_by_zero
    );

    // Sequencer side
    modport slave (
        input  i_flush, i_start, i_funct, i_rs, i_rt,
        output o_hi, o_lo, o_busy, o_stall, o_done, o_div_by_zero
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative MIPS-style HI/LO unit: 32-step shift-add multiply and
// restoring divide on operand magnitudes, sign fixed up at the final write.
module mult_div_sequencer #(
    parameter int DATA_BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BUS_WIDTH = 6,
    parameter int COUNT_WIDTH         = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    mult_div_sequencer_if.slave  bus
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int FW = ALU_FUNCT_BUS_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [FW-1:0] F_MFHI  = FW'(8'h10);
    localparam logic [FW-1:0] F_MTHI  = FW'(8'h11);
    localparam logic [FW-1:0] F_MFLO  = FW'(8'h12);
    localparam logic [FW-1:0] F_MTLO  = FW'(8'h13);
    localparam logic [FW-1:0] F_MULT  = FW'(8'h18);
    localparam logic [FW-1:0] F_MULTU = FW'(8'h19);
    localparam logic [FW-1:0] F_DIV   = FW'(8'h1A);
    localparam logic [FW-1:0] F_DIVU  = FW'(8'h1B);

    // Counter start value: W steps in total, the last one taken at count 0
    localparam logic [COUNT_WIDTH-1:0] LAST_STEP = COUNT_WIDTH'(W - 1);

    logic [1:0]             state;
    logic [COUNT_WIDTH-1:0] count;
    logic [W-1:0]           hi_q;
    logic [W-1:0]           lo_q;
    logic [W-1:0]           acc;      // partial product high half / partial remainder
    logic [W-1:0]           shreg;    // multiplier bits / dividend bits -> quotient
    logic [W-1:0]           operand;  // multiplicand / divisor magnitude
    logic                   is_signed;
    logic                   neg_main; // product or quotient is negative
    logic                   neg_rem;  // remainder takes dividend sign
    logic                   done_q;
    logic                   dbz_q;

    logic                   req_signed;
    logic                   rs_neg;
    logic                   rt_neg;
    logic [W:0]             mul_sum;
    logic [W-1:0]           mul_acc_next;
    logic [W-1:0]           mul_sh_next;
    logic [W:0]             div_shift;
    logic [W:0]             div_diff;
    logic                   div_fits;
    logic [W-1:0]           div_acc_next;
    logic [W-1:0]           div_sh_next;
    logic [2*W-1:0]         product;

    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x,
                                               input logic signed_op);
        logic [W-1:0] r;
        r = x;
        if (signed_op && x[W-1]) r = '0 - x;
        return r;
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] x, input logic neg);
        return neg ? ('0 - x) : x;
    endfunction

    function automatic logic [2*W-1:0] apply_sign_wide(input logic [2*W-1:0] x,
                                                       input logic neg);
        return neg ? ('0 - x) : x;
    endfunction

    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;
    assign bus.o_busy        = (state != ST_IDLE);
    assign bus.o_stall       = bus.i_start & bus.o_busy;
    assign bus.o_done        = done_q;
    assign bus.o_div_by_zero = dbz_q;

    // Request decode: signedness and operand signs of the incoming op
    always_comb begin
        req_signed = (bus.i_funct == F_MULT) || (bus.i_funct == F_DIV);
        rs_neg     = req_signed & bus.i_rs[W-1];
        rt_neg     = req_signed & bus.i_rt[W-1];
    end

    // One multiply step and one restoring-divide step, plus the signed product
    always_comb begin
        mul_sum      = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        mul_acc_next = mul_sum[W:1];
        mul_sh_next  = {mul_sum[0], shreg[W-1:1]};
        div_shift    = {acc, shreg[W-1]};
        div_diff     = div_shift - {1'b0, operand};
        div_fits     = ~div_diff[W];
        div_acc_next = div_fits ? div_diff[W-1:0] : div_shift[W-1:0];
        div_sh_next  = {shreg[W-2:0], div_fits};
        product      = apply_sign_wide({mul_acc_next, mul_sh_next}, neg_main);
    end

    // Sequencer FSM, iteration datapath and architectural HI/LO
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc       <= '0;
            shreg     <= '0;
            operand   <= '0;
            is_signed <= 1'b0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (bus.i_flush) begin
                // Abort wins over everything, including a same-cycle request
                state <= ST_IDLE;
                count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.i_start) begin
                            case (bus.i_funct)
                                F_MTHI: hi_q <= bus.i_rs;
                                F_MTLO: lo_q <= bus.i_rs;
                                F_MFHI, F_MFLO: ;
                                F_MULT, F_MULTU: begin
                                    operand   <= magnitude(bus.i_rs, req_signed);
                                    shreg     <= magnitude(bus.i_rt, req_signed);
                                    acc       <= '0;
                                    is_signed <= req_signed;
                                    neg_main  <= rs_neg ^ rt_neg;
                                    neg_rem   <= 1'b0;
                                    count     <= LAST_STEP;
                                    state     <= ST_MUL;
                                end
                                F_DIV, F_DIVU: begin
                                    if (bus.i_rt == '0) begin
                                        done_q <= 1'b1;
                                        dbz_q  <= 1'b1;
                                    end else begin
                                        operand   <= magnitude(bus.i_rt, req_signed);
                                        shreg     <= magnitude(bus.i_rs, req_signed);
                                        acc       <= '0;
                                        is_signed <= req_signed;
                                        neg_main  <= rs_neg ^ rt_neg;
                                        neg_rem   <= rs_neg;
                                        count     <= LAST_STEP;
                                        state     <= ST_DIV;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        acc   <= mul_acc_next;
                        shreg <= mul_sh_next;
                        if (count == '0) begin
                            hi_q   <= product[2*W-1:W];
                            lo_q   <= product[W-1:0];
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            count <= count - COUNT_WIDTH'(1);
                        end
                    end
                    ST_DIV: begin
                        acc   <= div_acc_next;
                        shreg <= div_sh_next;
                        if (count == '0) begin
                            lo_q   <= apply_sign(div_sh_next, neg_main);
                            hi_q   <= apply_sign(div_acc_next, neg_rem);
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            count <= count - COUNT_WIDTH'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Recorded for debug visibility of the in-flight op's signedness
    logic unused_signed;
    assign unused_signed = is_signed;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: latency, signed/unsigned results,
// divide-by-zero, stall, flush and asynchronous reset behaviour.
module tb_mult_div_sequencer;
    localparam int DW = 32;
    localparam int FW = 6;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_div_sequencer_if #(.DATA_BUS_WIDTH(DW), .ALU_FUNCT_BUS_WIDTH(FW)) bus ();

    mult_div_sequencer #(
        .DATA_BUS_WIDTH(DW), .ALU_FUNCT_BUS_WIDTH(FW), .COUNT_WIDTH(5)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    // Present one request for exactly one edge, return 1ns after it
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.i_start = 1'b1; bus.i_funct = f; bus.i_rs = a; bus.i_rt = b;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    // Issue and wait (bounded) for o_done; lat counts edges after accept
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
        issue(f, a, b);
        lat = 0; busy_cnt = 0;
        while (bus.o_done !== 1'b1 && lat < 40) begin
            if (bus.o_busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.i_flush = 1'b0; bus.i_start = 1'b1; bus.i_funct = F_MULT;
        bus.i_rs = 32'h5; bus.i_rt = 32'h7;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.o_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", bus.o_hi, 32'h0); end
        checks++; if (bus.o_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", bus.o_lo, 32'h0); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.o_done); end
        checks++; if (bus.o_div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", bus.o_div_by_zero); end
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.o_stall); end
        bus.i_start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", bus.o_busy); end
    endtask

    task automatic test_mult();
        int lat, bc;
        do_op(F_MULT, 32'hFFFFFFFF, 32'h00000002, lat, bc);
        checks++; if (lat !== 32) begin errors++; $display("FAIL mult_latency got %0d want 32", lat); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL mult_busy_cycles got %0d want 32", bc); end
        checks++; if (bus.o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want FFFFFFFF", bus.o_hi); end
        checks++; if (bus.o_lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got %h want FFFFFFFE", bus.o_lo); end
        checks++; if (bus.o_div_by_zero !== 1'b0) begin errors++; $display("FAIL mult_dbz got %b want 0", bus.o_div_by_zero); end
        @(posedge clk); #1;
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", bus.o_done); end
        do_op(F_MULTU, 32'hFFFFFFFF, 32'h00000002, lat, bc);
        checks++; if (bus.o_hi !== 32'h00000001) begin errors++; $display("FAIL multu_hi got %h want 00000001", bus.o_hi); end
        checks++; if (bus.o_lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h want FFFFFFFE", bus.o_lo); end
        do_op(F_MULT, 32'h80000000, 32'h80000000, lat, bc);
        checks++; if (bus.o_hi !== 32'h40000000) begin errors++; $display("FAIL mult_minmin_hi got %h want 40000000", bus.o_hi); end
        checks++; if (bus.o_lo !== 32'h00000000) begin errors++; $display("FAIL mult_minmin_lo got %h want 00000000", bus.o_lo); end
    endtask

    task automatic test_div();
        int lat, bc;
        do_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, lat, bc);
        checks++; if (lat !== 32) begin errors++; $display("FAIL div_latency got %0d want 32", lat); end
        checks++; if (bus.o_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want FFFFFFFD", bus.o_lo); end
        checks++; if (bus.o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want FFFFFFFF", bus.o_hi); end
        do_op(F_DIVU, 32'd100, 32'd7, lat, bc);
        checks++; if (bus.o_lo !== 32'h0000000E) begin errors++; $display("FAIL divu_lo got %h want 0000000E", bus.o_lo); end
        checks++; if (bus.o_hi !== 32'h00000002) begin errors++; $display("FAIL divu_hi got %h want 00000002", bus.o_hi); end
        do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        checks++; if (bus.o_lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", bus.o_lo); end
        checks++; if (bus.o_hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", bus.o_hi); end
        do_op(F_DIV, 32'd7, 32'hFFFFFFFE, lat, bc);
        checks++; if (bus.o_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdiv_lo got %h want FFFFFFFD", bus.o_lo); end
        checks++; if (bus.o_hi !== 32'h00000001) begin errors++; $display("FAIL div_negdiv_hi got %h want 00000001", bus.o_hi); end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        issue(F_MTHI, 32'h11111111, 32'h0);
        checks++; if (bus.o_hi !== 32'h11111111) begin errors++; $display("FAIL mthi got %h want 11111111", bus.o_hi); end
        issue(F_MTLO, 32'h22222222, 32'h0);
        checks++; if (bus.o_lo !== 32'h22222222) begin errors++; $display("FAIL mtlo got %h want 22222222", bus.o_lo); end
        do_op(F_DIVU, 32'd5, 32'd0, lat, bc);
        checks++; if (lat !== 0) begin errors++; $display("FAIL dbz_latency got %0d want 0", lat); end
        checks++; if (bus.o_div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", bus.o_div_by_zero); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL dbz_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_hi !== 32'h11111111) begin errors++; $display("FAIL dbz_hi got %h want 11111111", bus.o_hi); end
        checks++; if (bus.o_lo !== 32'h22222222) begin errors++; $display("FAIL dbz_lo got %h want 22222222", bus.o_lo); end
        @(posedge clk); #1;
        checks++; if (bus.o_div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_pulse got %b want 0", bus.o_div_by_zero); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL dbz_done_pulse got %b want 0", bus.o_done); end
    endtask

    task automatic test_undefined_funct();
        bus.i_start = 1'b1; bus.i_funct = 6'h05; bus.i_rs = 32'hDEADBEEF; bus.i_rt = 32'h3;
        #1;
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL undef_stall got %b want 0", bus.o_stall); end
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL undef_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL undef_done got %b want 0", bus.o_done); end
        checks++; if (bus.o_hi !== 32'h11111111) begin errors++; $display("FAIL undef_hi got %h want 11111111", bus.o_hi); end
        checks++; if (bus.o_lo !== 32'h22222222) begin errors++; $display("FAIL undef_lo got %h want 22222222", bus.o_lo); end
    endtask

    task automatic test_stall_mflo();
        int n;
        issue(F_MULT, 32'h12345678, 32'h00000010);
        repeat (2) @(posedge clk);
        #1;
        bus.i_start = 1'b1; bus.i_funct = F_MFLO; bus.i_rs = 32'h0; bus.i_rt = 32'h0;
        #1;
        n = 0;
        while (bus.o_stall === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        checks++; if (n !== 30) begin errors++; $display("FAIL stall_cycles got %0d want 30", n); end
        checks++; if (bus.o_done !== 1'b1) begin errors++; $display("FAIL stall_release_done got %b want 1", bus.o_done); end
        checks++; if (bus.o_lo !== 32'h23456780) begin errors++; $display("FAIL stall_lo got %h want 23456780", bus.o_lo); end
        checks++; if (bus.o_hi !== 32'h00000001) begin errors++; $display("FAIL stall_hi got %h want 00000001", bus.o_hi); end
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL mflo_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_lo !== 32'h23456780) begin errors++; $display("FAIL mflo_lo got %h want 23456780", bus.o_lo); end
    endtask

    task automatic test_flush();
        int dn, lat, bc;
        issue(F_MTHI, 32'hAAAA0000, 32'h0);
        issue(F_MTLO, 32'h0000BBBB, 32'h0);
        issue(F_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.o_busy); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_done === 1'b1) dn++;
            @(posedge clk); #1;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", dn); end
        checks++; if (bus.o_hi !== 32'hAAAA0000) begin errors++; $display("FAIL flush_hi got %h want AAAA0000", bus.o_hi); end
        checks++; if (bus.o_lo !== 32'h0000BBBB) begin errors++; $display("FAIL flush_lo got %h want 0000BBBB", bus.o_lo); end
        bus.i_flush = 1'b1;
        issue(F_MULT, 32'd3, 32'd5);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL flush_override_busy got %b want 0", bus.o_busy); end
        issue(F_MTHI, 32'h12121212, 32'h0);
        bus.i_flush = 1'b0;
        checks++; if (bus.o_hi !== 32'hAAAA0000) begin errors++; $display("FAIL flush_override_mthi got %h want AAAA0000", bus.o_hi); end
        do_op(F_MULTU, 32'd3, 32'd5, lat, bc);
        checks++; if (lat !== 32) begin errors++; $display("FAIL after_flush_latency got %0d want 32", lat); end
        checks++; if (bus.o_lo !== 32'd15) begin errors++; $display("FAIL after_flush_lo got %h want 0000000F", bus.o_lo); end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        issue(F_MULT, 32'h00001234, 32'h00000010);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_hi !== 32'h0) begin errors++; $display("FAIL midreset_hi got %h want 0", bus.o_hi); end
        checks++; if (bus.o_lo !== 32'h0) begin errors++; $display("FAIL midreset_lo got %h want 0", bus.o_lo); end
        @(posedge clk); #1;
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", bus.o_done); end
        @(negedge clk); rst_n = 1'b1;
        do_op(F_MULTU, 32'd6, 32'd7, lat, bc);
        checks++; if (lat !== 32) begin errors++; $display("FAIL first_edge_accept_latency got %0d want 32", lat); end
        checks++; if (bus.o_lo !== 32'd42) begin errors++; $display("FAIL first_edge_lo got %h want 0000002A", bus.o_lo); end
        checks++; if (bus.o_hi !== 32'd0) begin errors++; $display("FAIL first_edge_hi got %h want 00000000", bus.o_hi); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(F_MULTU, 32'd9, 32'd9);
        bus.i_start = 1'b1; bus.i_funct = F_DIVU; bus.i_rs = 32'd81; bus.i_rt = 32'd9;
        #1;
        n = 0;
        while (bus.o_stall === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL b2b_stall_cycles got %0d want 32", n); end
        checks++; if (bus.o_lo !== 32'd81) begin errors++; $display("FAIL b2b_first_lo got %h want 00000051", bus.o_lo); end
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b want 1", bus.o_busy); end
        n = 0;
        while (bus.o_done !== 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL b2b_second_latency got %0d want 32", n); end
        checks++; if (bus.o_lo !== 32'd9) begin errors++; $display("FAIL b2b_second_lo got %h want 00000009", bus.o_lo); end
        checks++; if (bus.o_hi !== 32'd0) begin errors++; $display("FAIL b2b_second_hi got %h want 00000000", bus.o_hi); end
    endtask

    initial begin
        bus.i_flush = 1'b0; bus.i_start = 1'b0; bus.i_funct = '0;
        bus.i_rs = '0; bus.i_rt = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_undefined_funct();
        test_stall_mflo();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
